logic16_stage: RTL

- Registered, back-pressure-aware capture stage that sits directly downstream of the 16-bit bitwise gate arrays (xnor16, and16, or16, ...).
- Accepts one 16-bit gate result per transfer, derives status flags at capture, and presents data plus flags to the consumer (ALU output mux / register file write port).
- Two-entry skid buffer, so in_ready is a registered signal with no combinational path from out_ready.

---
 rtl/logic16_pkg.sv | 28 ++
 rtl/flag_gen16.sv | 22 ++
 rtl/logic16_stage.sv | 132 +++++++++++++
 3 files changed

// File: rtl/logic16_pkg.sv
// rtl/logic16_pkg.sv - shared constants and types for the logic16 capture stage
// Optional parity support is enabled by LOGIC16_STAGE_PARITY_EN.
package logic16_pkg;

    localparam int WIDTH_DEF = 16;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    localparam int FLG_ZR  = 0;
    localparam int FLG_NG  = 1;
    localparam int FLG_EQ  = 2;
    localparam int FLG_PAR = 3;

`ifdef LOGIC16_STAGE_PARITY_EN
    localparam int FLG_W = 4;
`else
    localparam int FLG_W = 3;
`endif

    typedef enum logic [1:0] {
        STATE_EMPTY = ST_EMPTY,
        STATE_ONE   = ST_ONE,
        STATE_TWO   = ST_TWO
    } state_t;

endpackage

// File: rtl/flag_gen16.sv
// rtl/flag_gen16.sv - combinational status flags for one gate-array result
// Parity flag present only when LOGIC16_STAGE_PARITY_EN is defined.
module flag_gen16
    import logic16_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] i_data,
    output logic [FLG_W-1:0] o_flags
);

    always_comb begin
        o_flags          = '0;
        o_flags[FLG_ZR]  = (i_data == '0);
        o_flags[FLG_NG]  = i_data[WIDTH-1];
        o_flags[FLG_EQ]  = &i_data;
`ifdef LOGIC16_STAGE_PARITY_EN
        o_flags[FLG_PAR] = ^i_data;
`endif
    end

endmodule

// File: rtl/logic16_stage.sv
// rtl/logic16_stage.sv - two-entry skid capture stage for 16-bit gate results
// Optional parity flag and sticky parity check enabled by LOGIC16_STAGE_PARITY_EN.
module logic16_stage
    import logic16_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zr,
    output logic             out_ng,
`ifdef LOGIC16_STAGE_PARITY_EN
    output logic             out_eq,
    output logic             out_par,
    input  logic             in_par_chk,
    output logic             par_err
`else
    output logic             out_eq
`endif
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_main_data;
    logic [FLG_W-1:0]   r_main_flg;
    logic [WIDTH-1:0]   r_skid_data;
    logic [FLG_W-1:0]   r_skid_flg;
    logic [FLG_W-1:0]   w_in_flg;
    logic               w_in_xfer;
    logic               w_out_xfer;
    logic               w_load_main_in;
    logic               w_load_main_skid;
    logic               w_load_skid;

    flag_gen16 #(
        .WIDTH (WIDTH)
    ) u_flag_gen (
        .i_data  (in_data),
        .o_flags (w_in_flg)
    );

    // Handshake outputs decode registered state only, so no out_ready -> in_ready path.
    assign in_ready   = (r_state != STATE_TWO);
    assign out_valid  = (r_state != STATE_EMPTY);
    assign w_in_xfer  = in_valid && in_ready;
    assign w_out_xfer = out_valid && out_ready;

    always_comb begin
        w_state_nxt      = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        case (r_state)
            STATE_EMPTY: begin
                if (w_in_xfer) begin
                    w_state_nxt    = STATE_ONE;
                    w_load_main_in = 1'b1;
                end
            end
            STATE_ONE: begin
                if (w_in_xfer && w_out_xfer) begin
                    w_load_main_in = 1'b1;
                end else if (w_in_xfer) begin
                    w_state_nxt = STATE_TWO;
                    w_load_skid = 1'b1;
                end else if (w_out_xfer) begin
                    w_state_nxt = STATE_EMPTY;
                end
            end
            STATE_TWO: begin
                if (w_out_xfer) begin
                    w_state_nxt      = STATE_ONE;
                    w_load_main_skid = 1'b1;
                end
            end
            default: begin
                w_state_nxt = STATE_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= STATE_EMPTY;
            r_main_data <= '0;
            r_main_flg  <= '0;
            r_skid_data <= '0;
            r_skid_flg  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load_main_in) begin
                r_main_data <= in_data;
                r_main_flg  <= w_in_flg;
            end else if (w_load_main_skid) begin
                r_main_data <= r_skid_data;
                r_main_flg  <= r_skid_flg;
            end
            if (w_load_skid) begin
                r_skid_data <= in_data;
                r_skid_flg  <= w_in_flg;
            end
        end
    end

    assign out_data = r_main_data;
    assign out_zr   = r_main_flg[FLG_ZR];
    assign out_ng   = r_main_flg[FLG_NG];
    assign out_eq   = r_main_flg[FLG_EQ];

`ifdef LOGIC16_STAGE_PARITY_EN
    logic r_par_err;

    // Sticky: once a mismatching transfer is seen only reset clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_par_err <= 1'b0;
        end else if (w_in_xfer && (in_par_chk != w_in_flg[FLG_PAR])) begin
            r_par_err <= 1'b1;
        end
    end

    assign out_par = r_main_flg[FLG_PAR];
    assign par_err = r_par_err;
`endif

endmodule
